led_bank_arbiter: RTL and testbench
===================================

// Module: led_bank_arbiter
// PURPOSE
//  Shares the 12-bit front-panel LED bank between NREQ requesters and the idle cylon pattern.
//  Round-robin arbitration among requesters; each grant has a minimum dwell and a maximum hold,
//  both counted in prescaled visual ticks.
//  With no requests, the cylon pattern (idle_pat) passes through. Sits between the cylon generator,
//  the status sources, and the LED output drivers.
// PARAMETERS
//  NREQ    4   number of requesters (port 0..NREQ-1)
//  MXLED   12  LED bank width
//  MXPRE   21  prescaler width; use 4 in simulation
//  DWELL   2   minimum ticks a grant is held (>=1)
//  MAXHOLD 8   ticks after which a grant is forced to rotate if others are pending (>DWELL)
// PORTS
//  clock    in   1           system clock, 40 MHz
//  reset    in   1           synchronous, active-high
//  rate     in   2           tick rate select; prescaler step = rate+1
//  req      in   NREQ        level requests; bit i = requester i
//  pat      in   NREQ*MXLED  requester patterns; requester i uses pat[i*MXLED +: MXLED]
//  idle_pat in   MXLED       cylon pattern, shown when no grant is active
//  led_out  out  MXLED       registered LED drive
//  grant    out  NREQ        registered one-hot grant; 0 while IDLE
//  busy     out  1           1 while in GRANT or DWELL
// BEHAVIOUR
//  Reset: all values below apply from the edge on which reset is sampled high.
//   - led_out=0, grant=0, busy=0, state=IDLE
//   - prescaler=0, rr_ptr=0, tick counters=0, snapshot=0
//  Tick:
//   - prescaler += rate+1 every clock (MXPRE bits).
//   - tick = carry-out of that add. Carry-out guarantees no missed tick for any rate.
//  Round-robin select: the lowest i at or after rr_ptr, modulo NREQ, with req[i]=1.
//  States:
//   - IDLE: led_out <= idle_pat every clock.
//       If any req is high, go to GRANT on the next edge:
//       grant <= select, led_out <= pat of select, tick count cleared.
//       Latency: req high in cycle N -> grant and led_out valid in cycle N+1.
//   - GRANT: while req[g] is high, led_out <= pat[g] (live tracking).
//       Tick count increments on each tick.
//       If req[g] drops before the count reaches DWELL: snapshot the last led_out, go to DWELL.
//       When count >= DWELL:
//         * if no other req is pending, stay in GRANT while req[g] is high, else release;
//         * if another req is pending and req[g] has dropped, release;
//         * if count reaches MAXHOLD and another req is pending, release even if req[g] is high.
//   - DWELL: led_out holds the snapshot; grant stays on g.
//       Release when the tick count reaches DWELL.
//       A reassertion of req[g] during DWELL returns to GRANT; the count is not cleared.
//   - Release (same edge):
//       rr_ptr <= g+1 mod NREQ.
//       If any other req is pending, grant the new select directly (GRANT, count=0, no IDLE cycle).
//       Otherwise go to IDLE; grant=0 and led_out <= idle_pat on that edge.
//  Boundaries:
//   - Simultaneous requests: resolved by rr_ptr.
//   - Tick on the same edge as a release: the count applies to the new grant as 0.
//   - Counters saturate at MAXHOLD.
//   - NREQ=1: MAXHOLD never forces a rotate.
//   - Reset mid-grant: back to IDLE on the same edge.
//  grant is never multi-hot and never points to a requester whose req was low at the grant edge.
// STRUCTURE
//  Include file led_bank_defs.vh:
//   - state encodings IDLE/GRANT/DWELL (2-bit);
//   - counter width macro: clog2(MAXHOLD+1).
//  Sub-module led_tick_gen (clock, reset, rate -> tick): the prescaler with carry-out tick.
//   Shared with the cylon display rework.
//  Arbiter FSM, round-robin select, and output registers live in this module.
// TESTING  (MXPRE=4, DWELL=2, MAXHOLD=8, NREQ=4)
//  1. No req, idle_pat=12'h001 then 12'h002 -> led_out follows 1 cycle later; grant=0, busy=0.
//  2. req=4'b0100, pat2=12'hABC -> next cycle grant=4'b0100 and led_out=12'hABC.
//     Drop req -> return to IDLE only after 2 ticks.
//  3. req=4'b1010 together, rr_ptr=0 -> grant 0010 first.
//     After the DWELL release, grant 1000 with no IDLE cycle; rr_ptr then = 0.
//  4. req0 held high, req1 high from start -> grant0 forced off after exactly 8 ticks; grant1 next.
//  5. rate=3 -> tick period = 2^4/4 = 4 clocks, checked for 64 clocks with no missed tick.
//  6. reset pulsed during GRANT with led_out=12'hFFF -> next cycle led_out=0, grant=0, state IDLE.
//     Then resumes following idle_pat.

Source files
------------

// File: rtl/led_bank_arbiter_pkg.sv
// Shared types for the LED bank arbiter: FSM state encoding and counter sizing.
// Pure declarations; no logic.
package led_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  // Tick counters saturate at MAXHOLD, so they need to hold 0..MAXHOLD.
  function automatic int cnt_width(input int maxhold);
    return $clog2(maxhold + 1);
  endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// Request/pattern inputs and LED/grant outputs of the LED bank arbiter.
// master = status sources + cylon side, slave = arbiter.
interface led_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int MXLED = 12
);
  import led_bank_arbiter_pkg::*;

  logic [1:0]            rate;
  logic [NREQ-1:0]       req;
  logic [NREQ*MXLED-1:0] pat;
  logic [MXLED-1:0]      idle_pat;
  logic [MXLED-1:0]      led_out;
  logic [NREQ-1:0]       grant;
  logic                  busy;

  modport master (output rate, req, pat, idle_pat, input led_out, grant, busy);
  modport slave  (input rate, req, pat, idle_pat, output led_out, grant, busy);
endinterface

// File: rtl/led_tick_gen.sv
// Visual tick prescaler: accumulates rate+1 per clock, tick is the carry-out of the add.
// tick is combinational from the prescaler register; no backpressure.
module led_tick_gen #(
  parameter int MXPRE = 21
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] rate,
  output logic       tick
);
  logic [MXPRE-1:0] pre;
  logic [2:0]       step;
  logic [MXPRE:0]   sum;

  assign step = {1'b0, rate} + 3'd1;
  assign sum  = {1'b0, pre} + (MXPRE+1)'(step);
  assign tick = sum[MXPRE];

  always_ff @(posedge clock) begin
    if (reset) pre <= '0;
    else       pre <= sum[MXPRE-1:0];
  end
endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing the LED bank between requesters and the idle cylon pattern.
// Registered outputs, one-cycle request-to-grant latency; requesters are never stalled, only rotated.
module led_bank_arbiter
  import led_bank_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MXLED   = 12,
  parameter int MXPRE   = 21,
  parameter int DWELL   = 2,
  parameter int MAXHOLD = 8
) (
  input logic              clock,
  input logic              reset,
  led_bank_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = cnt_width(MAXHOLD);

  state_t           state, state_nxt;
  logic [IW-1:0]    g_idx, g_nxt, rr_ptr, rr_nxt;
  logic [NREQ-1:0]  grant_r, grant_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
  logic [MXLED-1:0] snap, snap_nxt, led_r, led_nxt;
  logic             tick, rel, req_g, other_any;
  logic [NREQ-1:0]  other_req;
  logic [IW-1:0]    sel, other_sel;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    int t;
    t = int'(i) + 1;
    if (t >= NREQ) t = 0;
    return IW'(t);
  endfunction

  // Lowest requester at or after start, modulo NREQ; start when nothing is set.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] start);
    logic [IW-1:0] pick;
    int            t;
    pick = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      t = int'(start) + k;
      if (t >= NREQ) t = t - NREQ;
      if (r[t]) pick = IW'(t);
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NREQ-1:0] oh;
    for (int k = 0; k < NREQ; k++) oh[k] = (int'(i) == k);
    return oh;
  endfunction

  function automatic logic [MXLED-1:0] pat_of(input logic [NREQ*MXLED-1:0] p, input logic [IW-1:0] i);
    return p[int'(i)*MXLED +: MXLED];
  endfunction

  led_tick_gen #(.MXPRE(MXPRE)) u_tick (
    .clock (clock),
    .reset (reset),
    .rate  (bus.rate),
    .tick  (tick)
  );

  assign req_g     = bus.req[g_idx];
  assign other_req = bus.req & ~grant_r;
  assign other_any = |other_req;
  assign sel       = rr_pick(bus.req, rr_ptr);
  assign other_sel = rr_pick(other_req, wrap_inc(g_idx));
  assign cnt_inc   = (tick && cnt < CW'(MAXHOLD)) ? cnt + 1'b1 : cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      g_idx   <= '0;
      grant_r <= '0;
      cnt     <= '0;
      snap    <= '0;
      led_r   <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      g_idx   <= g_nxt;
      grant_r <= grant_nxt;
      cnt     <= cnt_nxt;
      snap    <= snap_nxt;
      led_r   <= led_nxt;
      rr_ptr  <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g_idx;
    grant_nxt = grant_r;
    cnt_nxt   = cnt;
    snap_nxt  = snap;
    led_nxt   = led_r;
    rr_nxt    = rr_ptr;
    rel       = 1'b0;
    case (state)
      ST_IDLE: begin
        led_nxt = bus.idle_pat;
        if (|bus.req) begin
          state_nxt = ST_GRANT;
          g_nxt     = sel;
          grant_nxt = onehot(sel);
          led_nxt   = pat_of(bus.pat, sel);
          cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        cnt_nxt = cnt_inc;
        if (!req_g && cnt < CW'(DWELL)) begin
          state_nxt = ST_DWELL;
          snap_nxt  = led_r;
        end else if (cnt >= CW'(DWELL) && (!req_g || (other_any && cnt >= CW'(MAXHOLD)))) begin
          rel = 1'b1;
        end else begin
          led_nxt = pat_of(bus.pat, g_idx);
        end
      end
      ST_DWELL: begin
        led_nxt = snap;
        cnt_nxt = cnt_inc;
        if (cnt >= CW'(DWELL)) begin
          rel = 1'b1;
        end else if (req_g) begin
          state_nxt = ST_GRANT;
          led_nxt   = pat_of(bus.pat, g_idx);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Release hands straight over to the next pending requester, skipping IDLE.
    if (rel) begin
      rr_nxt  = wrap_inc(g_idx);
      cnt_nxt = '0;
      if (other_any) begin
        state_nxt = ST_GRANT;
        g_nxt     = other_sel;
        grant_nxt = onehot(other_sel);
        led_nxt   = pat_of(bus.pat, other_sel);
      end else begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
        led_nxt   = bus.idle_pat;
      end
    end
  end

  assign bus.led_out = led_r;
  assign bus.grant   = grant_r;
  assign bus.busy    = (state != ST_IDLE);
endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with a 4-bit prescaler; with rate=3 a tick
// lands on every 4th edge after the reset edge.
module tb_led_bank_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  led_bank_arbiter_if #(.NREQ(4), .MXLED(12)) bus ();

  led_bank_arbiter #(
    .NREQ(4), .MXLED(12), .MXPRE(4), .DWELL(2), .MAXHOLD(8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pats(input logic [11:0] p0, p1, p2, p3);
    bus.pat = {p3, p2, p1, p0};
  endtask

  initial begin
    bus.rate     = 2'd0;
    bus.req      = 4'b0000;
    bus.idle_pat = 12'h000;
    set_pats(12'h111, 12'h222, 12'hABC, 12'h333);

    // 1: idle pass-through
    do_reset();
    chk("rst_led", bus.led_out, 12'h000);
    chk("rst_grant", bus.grant, 4'b0000);
    chk("rst_busy", bus.busy, 1'b0);
    bus.idle_pat = 12'h001;
    chk("idle_lag", bus.led_out, 12'h000);
    step();
    chk("idle_001", bus.led_out, 12'h001);
    bus.idle_pat = 12'h002;
    chk("idle_hold", bus.led_out, 12'h001);
    step();
    chk("idle_002", bus.led_out, 12'h002);
    chk("idle_grant", bus.grant, 4'b0000);
    chk("idle_busy", bus.busy, 1'b0);

    // 2: single grant, drop before DWELL, release after 2 ticks (edges 4 and 8)
    bus.rate = 2'd3;
    do_reset();
    bus.idle_pat = 12'h0F0;
    bus.req = 4'b0100;
    step();
    chk("g2_grant", bus.grant, 4'b0100);
    chk("g2_led", bus.led_out, 12'hABC);
    chk("g2_busy", bus.busy, 1'b1);
    bus.req = 4'b0000;
    step();
    set_pats(12'h111, 12'h222, 12'hDEF, 12'h333);
    for (int e = 3; e <= 8; e++) begin
      step();
      chk("dwell_grant", bus.grant, 4'b0100);
      chk("dwell_led", bus.led_out, 12'hABC);
    end
    step();
    chk("dwell_rel_grant", bus.grant, 4'b0000);
    chk("dwell_rel_busy", bus.busy, 1'b0);
    chk("dwell_rel_led", bus.led_out, 12'h0F0);

    // 3: simultaneous requests, direct hand-over, rr_ptr wraps to 0
    set_pats(12'h111, 12'h222, 12'hABC, 12'h333);
    do_reset();
    bus.req = 4'b1010;
    step();
    chk("rr_first", bus.grant, 4'b0010);
    chk("rr_first_led", bus.led_out, 12'h222);
    bus.req = 4'b1000;
    for (int e = 2; e <= 8; e++) step();
    chk("rr_hold1", bus.grant, 4'b0010);
    step();
    chk("rr_second", bus.grant, 4'b1000);
    chk("rr_no_idle", bus.busy, 1'b1);
    chk("rr_second_led", bus.led_out, 12'h333);
    bus.req = 4'b0000;
    for (int e = 10; e <= 17; e++) step();
    chk("rr_idle", bus.grant, 4'b0000);
    bus.req = 4'b0101;
    step();
    chk("rr_ptr_wrap", bus.grant, 4'b0001);
    chk("rr_ptr_led", bus.led_out, 12'h111);

    // 4: MAXHOLD forced rotation after 8 ticks (ticks at edges 4..32)
    bus.req = 4'b0000;
    do_reset();
    bus.req = 4'b0011;
    step();
    chk("mh_start", bus.grant, 4'b0001);
    for (int e = 2; e <= 32; e++) begin
      step();
      chk("mh_hold", bus.grant, 4'b0001);
    end
    chk("mh_hold_led", bus.led_out, 12'h111);
    step();
    chk("mh_rotate", bus.grant, 4'b0010);
    chk("mh_rotate_led", bus.led_out, 12'h222);
    chk("mh_busy", bus.busy, 1'b1);

    // 5: tick period at rate=3 is 4 clocks
    bus.req = 4'b0000;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      chk("tick_period", dut.u_tick.tick, (k % 4) == 3);
      step();
    end

    // 6: reset during GRANT
    do_reset();
    set_pats(12'hFFF, 12'h222, 12'hABC, 12'h333);
    bus.req = 4'b0001;
    step();
    chk("pre_rst_led", bus.led_out, 12'hFFF);
    chk("pre_rst_grant", bus.grant, 4'b0001);
    reset = 1'b1;
    step();
    chk("mid_rst_led", bus.led_out, 12'h000);
    chk("mid_rst_grant", bus.grant, 4'b0000);
    chk("mid_rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    bus.req = 4'b0000;
    bus.idle_pat = 12'h055;
    step();
    chk("post_rst_led", bus.led_out, 12'h055);
    chk("post_rst_grant", bus.grant, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
